ps2_keymatrix: RTL
==================

# ps2_keymatrix

PS/2 keyboard receiver that converts scan codes into the LM80C 8×8 active-low key matrix `KM[7:0]`. The matrix is consumed by the PSG port-A scan logic in the `lm80c` top level. The block sits in the board wrapper between the raw PS/2 pins and `lm80c`, and is clocked by `sys_clock`. It deserialises PS/2 device-to-host frames, validates them, tracks make/break/extended prefixes, and sets or clears one matrix bit per recognised key.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 40000: maximum `sys_clock` cycles allowed between two PS/2 falling edges inside a frame.

Ports:
- `sys_clock`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `KM[7:0]`  out  8×8  key matrix, unpacked array of rows. Bit `KM[r][c]` is 0 while the key is pressed and 1 while it is released.
- `key_strobe`  out  1  one-cycle pulse on each matrix update.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Input sync:** 2-FF synchronisers `s1`, `s2` on both PS/2 inputs, plus `s3` holding the previous `s2` clock value. `fall = s3 & ~s2_clk`.
- **Deserialiser:** 11-bit frame, LSB first: start(0), d0..d7, odd parity, stop(1). On each `fall`, shift in `s2_data` and increment the 4-bit `bitcnt`.
- **Frame check:** on the cycle after `bitcnt` reaches 11, the frame is accepted only if start=0, stop=1 and parity over d0..d7 plus the parity bit is odd.
  - Accepted frame: pulse `code_valid` with `code[7:0]`.
  - Rejected frame: pulse `frame_err` and discard the byte.
  - `bitcnt` clears to 0 in either case.
- **Timeout:** a 16-bit idle counter runs while `bitcnt != 0` and resets on every `fall`. When it reaches `TIMEOUT_CYCLES`, `bitcnt` clears to 0 and the partial frame is dropped without pulsing `frame_err`.
- **Prefix FSM** (states IDLE, BRK, EXT, EXT_BRK), advanced only on `code_valid`:
  - IDLE: 0xE0 → EXT; 0xF0 → BRK; 0xAA → release all; any other code is a make → IDLE.
  - BRK: any code is a break → IDLE.
  - EXT: 0xF0 → EXT_BRK; any other code is an extended make → IDLE.
  - EXT_BRK: any code is an extended break → IDLE.
- **Mapping:** `{ext, code}` goes to the `keymap` lookup, which returns `{hit, row[2:0], col[2:0]}`.
  - Make with hit: `KM[row][col] <= 0`, pulse `key_strobe`.
  - Break with hit: `KM[row][col] <= 1`, pulse `key_strobe`.
  - No hit: FSM returns to IDLE, no strobe.
- **Release all:** 0xAA (keyboard BAT) in IDLE sets all `KM` to 8'hFF and pulses `key_strobe`.
- **Repeat makes:** typematic repeats rewrite an already-clear bit and still pulse `key_strobe`.
- Only one matrix bit changes per accepted code. Multiple keys may be held simultaneously; each key's bit is independent.

## Timing
- **Reset values:** `KM` all 8'hFF, `key_strobe`=0, `frame_err`=0, FSM=IDLE, `bitcnt`=0, idle counter=0. Sync flops reset to 1, the PS/2 bus idle level, so no false `fall` occurs after reset.
- **Reset mid-frame:** the partial frame is discarded, the prefix state is lost, and all keys read released.
- **Latency, counted from the first `sys_clock` edge after which the 11th `ps2_clk` falling edge is captured in `s1`:**
  - Edge 2: `s2` low.
  - Edge 3: bit shifted, `bitcnt` = 11.
  - Edge 4: `code_valid` / `frame_err`.
  - Edge 5: `KM` updated and `key_strobe` high for exactly that cycle.
- A `fall` on the same cycle as the timeout takes priority: the bit is shifted and the counter resets.
- Minimum valid PS/2 low/high phase is 4 `sys_clock` cycles. Faster toggling is unsupported.
- The block is receive-only and never drives the PS/2 lines.

## Structure
- Package `lm80c_kbd_pkg` holds:
  - the state enum `kbd_state_t`;
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_BAT`=8'hAA;
  - the function `keymap(input ext, input [7:0] code)` holding the LM80C layout. Fixed entries used by the bench: 0x1C ('A') → row 1 col 2; 0x5A (Enter) → row 0 col 7; ext 0x75 (Up) → row 7 col 4.
- One natural sub-module, `ps2_rx`, covering sync, deserialiser, parity check and timeout; it outputs `code_valid`, `code` and `frame_err`. The top level holds the FSM and the matrix.

## Test plan
- Frame 0x1C with correct parity → after 5 cycles `KM[1][2]`=0, `key_strobe` pulses once, every other bit stays 1.
- 0xF0, then 0x1C → `KM[1][2]` returns to 1 with one strobe; the 0xF0 frame itself produces no strobe.
- 0xE0 0x75, then 0xE0 0xF0 0x75 → `KM[7][4]` goes to 0, then back to 1. Plain 0x75 with no prefix leaves `KM` unchanged if unmapped.
- 0x1C sent with parity flipped → `frame_err` pulses once, `KM` stays 8'hFF, and the next good frame decodes normally.
- 5 bits of a frame, then idle for `TIMEOUT_CYCLES`+10 cycles, then a full 0x5A frame → `KM[0][7]`=0 with no `frame_err`.
- Press 0x1C and 0x5A, then send 0xAA → all `KM`=8'hFF. Separately, press 0x1C, assert `RESET` mid-way through the next frame for one cycle → all `KM`=8'hFF and both strobes 0.

Source files
------------

// File: rtl/lm80c_kbd_pkg.sv
// ---------------------------------------------------------------------------
// lm80c_kbd_pkg
// Shared types, constants and the LM80C key layout for the PS/2 keyboard
// front end.
//   kbd_state_t : prefix tracking states (IDLE, BRK, EXT, EXT_BRK)
//   key_loc_t   : lookup result {hit, row, col}
//   PS2_EXT / PS2_BRK / PS2_BAT : special scan codes
//   keymap()    : {ext, code} -> matrix position in the LM80C 8x8 matrix
// ---------------------------------------------------------------------------
package lm80c_kbd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } kbd_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_BAT = 8'hAA;

   typedef struct packed {
      logic       hit;
      logic [2:0] row;
      logic [2:0] col;
   } key_loc_t;

   function automatic key_loc_t loc_at(input logic [2:0] r, input logic [2:0] c);
      key_loc_t loc;
      loc.hit = 1'b1;
      loc.row = r;
      loc.col = c;
      return loc;
   endfunction

   // Set-2 scan codes; bit 8 of the selector is the E0 (extended) flag.
   function automatic key_loc_t keymap(input logic ext, input logic [7:0] code);
      key_loc_t loc;
      loc = '0;
      case ({ext, code})
         9'h016: loc = loc_at(3'd0, 3'd0);  // 1
         9'h01E: loc = loc_at(3'd0, 3'd1);  // 2
         9'h05A: loc = loc_at(3'd0, 3'd7);  // Enter
         9'h015: loc = loc_at(3'd1, 3'd0);  // Q
         9'h01D: loc = loc_at(3'd1, 3'd1);  // W
         9'h01C: loc = loc_at(3'd1, 3'd2);  // A
         9'h01B: loc = loc_at(3'd1, 3'd3);  // S
         9'h024: loc = loc_at(3'd2, 3'd0);  // E
         9'h02D: loc = loc_at(3'd2, 3'd1);  // R
         9'h023: loc = loc_at(3'd2, 3'd2);  // D
         9'h02B: loc = loc_at(3'd2, 3'd3);  // F
         9'h01A: loc = loc_at(3'd3, 3'd0);  // Z
         9'h022: loc = loc_at(3'd3, 3'd1);  // X
         9'h021: loc = loc_at(3'd3, 3'd2);  // C
         9'h02A: loc = loc_at(3'd3, 3'd3);  // V
         9'h029: loc = loc_at(3'd4, 3'd0);  // Space
         9'h012: loc = loc_at(3'd4, 3'd1);  // Left Shift
         9'h014: loc = loc_at(3'd4, 3'd2);  // Left Ctrl
         9'h076: loc = loc_at(3'd4, 3'd3);  // Esc
         9'h114: loc = loc_at(3'd4, 3'd4);  // Right Ctrl (E0)
         9'h045: loc = loc_at(3'd5, 3'd0);  // 0
         9'h04D: loc = loc_at(3'd5, 3'd1);  // P
         9'h04B: loc = loc_at(3'd5, 3'd2);  // L
         9'h03A: loc = loc_at(3'd5, 3'd3);  // M
         9'h005: loc = loc_at(3'd6, 3'd0);  // F1
         9'h006: loc = loc_at(3'd6, 3'd1);  // F2
         9'h004: loc = loc_at(3'd6, 3'd2);  // F3
         9'h175: loc = loc_at(3'd7, 3'd4);  // Up (E0)
         9'h172: loc = loc_at(3'd7, 3'd5);  // Down (E0)
         9'h16B: loc = loc_at(3'd7, 3'd6);  // Left (E0)
         9'h174: loc = loc_at(3'd7, 3'd7);  // Right (E0)
         default: loc = '0;
      endcase
      return loc;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host receiver: synchronises the raw lines, deserialises
// 11-bit frames (start, d0..d7, odd parity, stop) and validates them.
// Ports:
//   i_clk, i_rst      : system clock, synchronous active-high reset
//   i_ps2_clk/_data   : raw asynchronous PS/2 lines
//   o_code_valid      : one-cycle pulse, o_code holds an accepted byte
//   o_code[7:0]       : last accepted scan code
//   o_frame_err       : one-cycle pulse when a complete frame is rejected
// ---------------------------------------------------------------------------
module ps2_rx #(
   parameter int TIMEOUT_CYCLES = 40000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_code_valid,
   output logic [7:0] o_code,
   output logic       o_frame_err
);
   import lm80c_kbd_pkg::*;

   logic        r_s1_clk, r_s2_clk, r_s3_clk;
   logic        r_s1_data, r_s2_data;
   logic [10:0] r_shift;
   logic [3:0]  r_bitcnt;
   logic [15:0] r_idle;

   logic w_fall, w_frame_done, w_frame_ok, w_timeout;

   assign w_fall       = r_s3_clk & ~r_s2_clk;
   assign w_frame_done = (r_bitcnt == 4'd11);
   // Bits arrive LSB first, so after 11 shifts: [0]=start, [8:1]=data,
   // [9]=parity, [10]=stop.
   assign w_frame_ok   = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
   assign w_timeout    = (r_bitcnt != 4'd0) && (r_idle == 16'(TIMEOUT_CYCLES));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // Bus idles high; resetting the synchronisers to 1 avoids a
         // spurious falling edge straight out of reset.
         r_s1_clk     <= 1'b1;
         r_s2_clk     <= 1'b1;
         r_s3_clk     <= 1'b1;
         r_s1_data    <= 1'b1;
         r_s2_data    <= 1'b1;
         r_shift      <= '0;
         r_bitcnt     <= '0;
         r_idle       <= '0;
         o_code_valid <= 1'b0;
         o_code       <= '0;
         o_frame_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge
         // value, which is what makes the s1->s2->s3 chain a real pipeline.
         r_s1_clk     <= i_ps2_clk;
         r_s2_clk     <= r_s1_clk;
         r_s3_clk     <= r_s2_clk;
         r_s1_data    <= i_ps2_data;
         r_s2_data    <= r_s1_data;
         o_code_valid <= 1'b0;
         o_frame_err  <= 1'b0;

         if (w_frame_done) begin
            r_bitcnt <= '0;
            r_idle   <= '0;
            if (w_frame_ok) begin
               o_code_valid <= 1'b1;
               o_code       <= r_shift[8:1];
            end else begin
               o_frame_err  <= 1'b1;
            end
         end else if (w_fall) begin
            // A falling edge beats a simultaneous timeout.
            r_shift  <= {r_s2_data, r_shift[10:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            r_idle   <= '0;
         end else if (w_timeout) begin
            // Stalled partial frame is dropped silently.
            r_bitcnt <= '0;
            r_idle   <= '0;
         end else if (r_bitcnt != 4'd0) begin
            r_idle   <= r_idle + 16'd1;
         end
      end
   end

endmodule

// File: rtl/ps2_keymatrix.sv
// ---------------------------------------------------------------------------
// ps2_keymatrix
// Converts PS/2 scan codes into the LM80C 8x8 active-low key matrix.
// Ports:
//   sys_clock, RESET : system clock, synchronous active-high reset
//   ps2_clk/ps2_data : raw asynchronous PS/2 lines (receive only)
//   KM[8]            : rows of the matrix, bit = 0 while the key is held
//   key_strobe       : one-cycle pulse on each matrix update
//   frame_err        : one-cycle pulse when a PS/2 frame is rejected
// ---------------------------------------------------------------------------
module ps2_keymatrix
   import lm80c_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40000
) (
   input  logic       sys_clock,
   input  logic       RESET,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] KM [8],
   output logic       key_strobe,
   output logic       frame_err
);

   logic       w_code_valid;
   logic [7:0] w_code;

   kbd_state_t r_state, w_next;
   logic       w_press, w_release, w_release_all, w_ext;
   key_loc_t   w_loc;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .i_clk        (sys_clock),
      .i_rst        (RESET),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_data   (ps2_data),
      .o_code_valid (w_code_valid),
      .o_code       (w_code),
      .o_frame_err  (frame_err)
   );

   // Prefix tracking: decides what an accepted code means.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      w_next        = r_state;
      w_press       = 1'b0;
      w_release     = 1'b0;
      w_release_all = 1'b0;
      w_ext         = 1'b0;
      if (w_code_valid) begin
         case (r_state)
            IDLE: begin
               if (w_code == PS2_EXT)      w_next = EXT;
               else if (w_code == PS2_BRK) w_next = BRK;
               else if (w_code == PS2_BAT) w_release_all = 1'b1;
               else                        w_press = 1'b1;
            end
            BRK: begin
               w_release = 1'b1;
               w_next    = IDLE;
            end
            EXT: begin
               if (w_code == PS2_BRK) begin
                  w_next = EXT_BRK;
               end else begin
                  w_press = 1'b1;
                  w_ext   = 1'b1;
                  w_next  = IDLE;
               end
            end
            EXT_BRK: begin
               w_release = 1'b1;
               w_ext     = 1'b1;
               w_next    = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   assign w_loc = keymap(w_ext, w_code);

   always_ff @(posedge sys_clock) begin
      if (RESET) begin
         // NOTE: the matrix is a small flop array, not RAM, so it is reset
         // explicitly: every key must read released after reset.
         for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
         key_strobe <= 1'b0;
         r_state    <= IDLE;
      end else begin
         r_state    <= w_next;
         key_strobe <= 1'b0;
         if (w_release_all) begin
            for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
            key_strobe <= 1'b1;
         end else if ((w_press || w_release) && w_loc.hit) begin
            // Repeated makes rewrite an already-clear bit and still strobe.
            KM[w_loc.row][w_loc.col] <= w_release;
            key_strobe <= 1'b1;
         end
      end
   end

endmodule
